nibble_add_sequencer: RTL and testbench
=======================================

Name: nibble_add_sequencer

Overview:
- Multi-nibble sequencer wrapped around the existing combinational 4-bit adder stage (a[3:0] + b[3:0] + cin produces a 5-bit sum).
- Accepts two wide operands over a valid/ready handshake.
- Feeds the adder one nibble per clock, LSB first, and carries bit 4 of each result into the next nibble.
- Assembles the wide sum and presents it with carry-out and signed-overflow on a valid/ready output.

Parameters:
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  initial carry-in.
- add_a  output  4  nibble of A driven to the adder.
- add_b  output  4  nibble of B driven to the adder.
- add_cin  output  1  carry driven to the adder.
- add_sum  input  5  adder result; bit 4 is carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  assembled sum.
- out_cout  output  1  final carry-out.
- out_ovf  output  1  two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, while rst_n=0):
  - State = IDLE.
  - Registers A, B, result, carry and idx clear to 0.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0.
  - in_ready=1, since it is decoded from IDLE.
  - add_a=0, add_b=0, add_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge: A<=in_a, B<=in_b, carry<=in_cin, idx<=0, result<=0, go to RUN.
- RUN:
  - Combinational drive: add_a=A[4*idx+:4], add_b=B[4*idx+:4], add_cin=carry.
  - Each edge: result[4*idx+:4]<=add_sum[3:0], carry<=add_sum[4].
  - If idx==NIBBLES-1, go to DONE; otherwise idx<=idx+1.
  - Exactly NIBBLES cycles spent in RUN.
  - The adder is combinational in the same cycle; no extra wait state.
- DONE:
  - out_valid=1; out_sum=result; out_cout=carry.
  - out_ovf = (A[W-1]==B[W-1]) && (result[W-1]!=A[W-1]).
  - Outputs are held stable while out_ready=0.
  - On out_ready=1, go to IDLE.
- add_a, add_b and add_cin are forced to 0 outside RUN.
- in_ready=0 in RUN and DONE; in_valid is ignored there, and operands are not sampled.
- Simultaneous out_ready in DONE and in_valid: the result is retired; new operands are accepted on the next cycle in IDLE (one-cycle bubble, by design).
- Latency: accept edge to out_valid high = NIBBLES+1 edges. Minimum throughput = one operation per NIBBLES+2 cycles.
- out_sum, out_cout and out_ovf are registered (or decoded from registers) only; no combinational path from add_sum to out_*.
- idx width = $clog2(NIBBLES). Wrap-around of idx never occurs because the FSM exits RUN at NIBBLES-1.
- Reset mid-operation: abort immediately to the reset values; the partial result is discarded.

Decomposition:
- Shared package holds:
  - state enum {IDLE, RUN, DONE};
  - constant NIBBLE_W=4;
  - constant ADD_RES_W=5.
- No sub-module: the 4-bit adder stays a separate existing block, wired at the parent level through the add_* ports.
- The bench instantiates the same adder (or a behavioural a+b+cin model) to close the loop.

Test Plan:
- NIBBLES=4, A=0x1234, B=0x4321, cin=0 -> after 5 edges out_valid=1, out_sum=0x5555, cout=0, ovf=0; add_a sequence 4,3,2,1.
- A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0; add_cin=1 on nibbles 1..3.
- A=0x7FFF, B=0x0001 -> out_sum=0x8000, cout=0, ovf=1.
- A=0x0000, B=0x0000, cin=1 -> out_sum=0x0001, cout=0.
- Backpressure:
  - out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and flags stable, in_ready=0.
  - In the same cycle, in_valid=1 with A=0xAAAA is ignored.
  - After out_ready=1, the next accepted op computes correctly.
- rst_n pulsed low two cycles into RUN -> all outputs at their reset values at once, in_ready=1.
  - Then A=0x0F0F, B=0x00F1 -> out_sum=0x1000, cout=0.

Source files
------------

// File: rtl/nibble_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial adder sequencer:
// FSM state type and codes, and the widths of the external 4-bit adder stage.
package nibble_add_sequencer_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int ADD_RES_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

endpackage

// File: rtl/nibble_add_sequencer.sv
// Multi-nibble add sequencer: captures two wide operands, walks them LSB
// nibble first through an external combinational 4-bit adder, chains the
// carry from one nibble to the next, and presents the assembled sum with
// carry-out and signed overflow until the consumer takes it.
module nibble_add_sequencer
    import nibble_add_sequencer_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   in_b,
    input  logic                          in_cin,
    output logic [NIBBLE_W-1:0]           add_a,
    output logic [NIBBLE_W-1:0]           add_b,
    output logic                          add_cin,
    input  logic [ADD_RES_W-1:0]          add_sum,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   out_sum,
    output logic                          out_cout,
    output logic                          out_ovf,
    output logic                          busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]       state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     result_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [IDX_W+1:0] bit_base;

    // Bit offset of the nibble currently being processed (idx * 4).
    assign bit_base = {idx, 2'b00};

    // Sequencing FSM plus operand, partial-result, carry and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            carry      <= 1'b0;
            idx        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg      <= in_a;
                        b_reg      <= in_b;
                        carry      <= in_cin;
                        idx        <= '0;
                        result_reg <= '0;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result_reg[bit_base +: NIBBLE_W] <= add_sum[NIBBLE_W-1:0];
                    carry <= add_sum[NIBBLE_W];
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Adder drive: current nibble pair and chained carry in RUN, zero otherwise.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == ST_RUN) begin
            add_a   = a_reg[bit_base +: NIBBLE_W];
            add_b   = b_reg[bit_base +: NIBBLE_W];
            add_cin = carry;
        end
    end

    // Handshake and result outputs, decoded only from registered state so
    // nothing from add_sum reaches out_* combinationally.
    always_comb begin
        in_ready  = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        out_ovf   = 1'b0;
        if (state == ST_DONE) begin
            out_valid = 1'b1;
            out_sum   = result_reg;
            out_cout  = carry;
            out_ovf   = (a_reg[W-1] == b_reg[W-1]) && (result_reg[W-1] != a_reg[W-1]);
        end
    end

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench for nibble_add_sequencer: closes the loop with a
// behavioural 4-bit adder and checks against whole-word arithmetic.
module tb_nibble_add_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [4:0]   add_sum;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int compareCount = 0;
    int failCount    = 0;

    nibble_add_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Behavioural stand-in for the existing 4-bit adder stage.
    assign add_sum = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Carry into nibble i from whole-word arithmetic on the low 4*i bits.
    function automatic logic refCarryIn(input logic [63:0] a, input logic [63:0] b, input logic cin, input int i);
        logic [63:0] mask;
        logic [63:0] s;
        mask = (64'd1 << (4 * i)) - 64'd1;
        s    = (a & mask) + (b & mask) + 64'(cin);
        return s[4 * i];
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_out_sum"},   64'(out_sum),   64'd0);
        checkOutput({tag, "_out_cout"},  64'(out_cout),  64'd0);
        checkOutput({tag, "_out_ovf"},   64'(out_ovf),   64'd0);
        checkOutput({tag, "_busy"},      64'(busy),      64'd0);
        checkOutput({tag, "_in_ready"},  64'(in_ready),  64'd1);
        checkOutput({tag, "_add_a"},     64'(add_a),     64'd0);
        checkOutput({tag, "_add_b"},     64'(add_b),     64'd0);
        checkOutput({tag, "_add_cin"},   64'(add_cin),   64'd0);
    endtask

    // One full operation: accept, RUN nibble checks, DONE with optional
    // backpressure, then retire (optionally together with a new in_valid).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input int holdCycles, input bit doBubble);
        logic [63:0]  full;
        logic [W-1:0] expSum;
        logic         expCout;
        logic         expOvf;
        full    = 64'(a) + 64'(b) + 64'(cin);
        expSum  = full[W-1:0];
        expCout = full[W];
        expOvf  = (a[W-1] == b[W-1]) && (expSum[W-1] != a[W-1]);

        @(negedge clk);
        checkOutput("accept_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;

        for (int i = 0; i < NIBBLES; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput($sformatf("run%0d_add_a", i),   64'(add_a),   64'((a >> (4 * i)) & 16'hF));
            checkOutput($sformatf("run%0d_add_b", i),   64'(add_b),   64'((b >> (4 * i)) & 16'hF));
            checkOutput($sformatf("run%0d_add_cin", i), 64'(add_cin), 64'(refCarryIn(64'(a), 64'(b), cin, i)));
            checkOutput($sformatf("run%0d_out_valid", i), 64'(out_valid), 64'd0);
            checkOutput($sformatf("run%0d_in_ready", i),  64'(in_ready),  64'd0);
            checkOutput($sformatf("run%0d_busy", i),      64'(busy),      64'd1);
        end

        @(negedge clk);
        for (int h = 0; h <= holdCycles; h++) begin
            checkOutput("done_out_valid", 64'(out_valid), 64'd1);
            checkOutput("done_out_sum",   64'(out_sum),   64'(expSum));
            checkOutput("done_out_cout",  64'(out_cout),  64'(expCout));
            checkOutput("done_out_ovf",   64'(out_ovf),   64'(expOvf));
            checkOutput("done_in_ready",  64'(in_ready),  64'd0);
            checkOutput("done_busy",      64'(busy),      64'd1);
            if (h < holdCycles) begin
                in_valid = 1'b1;
                in_a     = 16'hAAAA;
                in_b     = 16'h5555;
                @(negedge clk);
            end
        end

        in_valid  = doBubble;
        in_a      = 16'hAAAA;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("retire_out_valid", 64'(out_valid), 64'd0);
        checkOutput("retire_in_ready",  64'(in_ready),  64'd1);
        checkOutput("retire_busy",      64'(busy),      64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;

        applyStimulus(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        applyStimulus(16'h1357, 16'h2468, 1'b1, 5, 1'b0);
        applyStimulus(16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b1);
        applyStimulus(16'h2222, 16'h3333, 1'b0, 0, 1'b0);

        // Reset pulsed two cycles into RUN aborts the operation at once.
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = 16'h5A5A;
        in_b     = 16'hA5A5;
        in_cin   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetState("midrun_reset");
        @(negedge clk);
        checkResetState("midrun_reset_held");
        rst_n = 1'b1;
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            applyStimulus(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
